// File: rtl/cpu_common.sv
// Shared CPU-side types and constants; the data-memory arbiter state lives here.
package cpu_common;

  typedef enum logic {
    ARB_NORMAL = 1'b0,
    ARB_FORCE  = 1'b1
  } arb_state_t;

  localparam int DMEM_ARB_STARVE_LIMIT = 8;

  // Response tag: who owned the port last cycle and whether it was a read.
  typedef struct packed {
    logic dbg;
    logic rd;
  } dmem_rsp_tag_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: CPU has priority, the debug/DMA port
// is forced through for one cycle after STARVE_LIMIT consecutive refusals.
module dmem_arbiter
  import cpu_common::*;
#(
  parameter int STARVE_LIMIT = DMEM_ARB_STARVE_LIMIT
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] cpu_addr_i,
  input  logic        cpu_read_enable_i,
  input  logic [31:0] cpu_write_data_i,
  input  logic [3:0]  cpu_write_mask_i,
  output logic        cpu_stall_o,
  output logic [31:0] cpu_read_data_o,
  input  logic        dbg_req_i,
  input  logic [31:0] dbg_addr_i,
  input  logic [31:0] dbg_write_data_i,
  input  logic [3:0]  dbg_write_mask_i,
  output logic        dbg_gnt_o,
  output logic [31:0] dbg_read_data_o,
  output logic        dbg_rvalid_o,
  output logic [31:0] dmem_addr_o,
  output logic        dmem_read_enable_o,
  output logic [31:0] dmem_write_data_o,
  output logic [3:0]  dmem_write_mask_o,
  input  logic [31:0] dmem_read_data_i
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  arb_state_t      state_q, state_d;
  logic [SW-1:0]   starve_q, starve_d;
  dmem_rsp_tag_t   tag_q, tag_d;
  logic            cpu_active;
  logic            dbg_own;

  always_comb begin
    cpu_active  = cpu_read_enable_i | (|cpu_write_mask_i);
    dbg_own     = 1'b0;
    cpu_stall_o = 1'b0;
    if (!reset_i) begin
      if (state_q == ARB_FORCE) begin
        dbg_own     = dbg_req_i;
        cpu_stall_o = dbg_req_i & cpu_active;
      end else begin
        dbg_own     = dbg_req_i & ~cpu_active;
      end
    end
    dbg_gnt_o = dbg_own;

    // Idle or reset leaves the CPU address/data on the port with no strobes.
    if (dbg_own) begin
      dmem_addr_o        = dbg_addr_i;
      dmem_write_data_o  = dbg_write_data_i;
      dmem_read_enable_o = ~(|dbg_write_mask_i);
      dmem_write_mask_o  = dbg_write_mask_i;
    end else begin
      dmem_addr_o        = cpu_addr_i;
      dmem_write_data_o  = cpu_write_data_i;
      dmem_read_enable_o = cpu_read_enable_i & ~reset_i;
      dmem_write_mask_o  = cpu_write_mask_i & {4{~reset_i}};
    end

    if (dbg_req_i && !dbg_own)
      starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + 1'b1;
    else
      starve_d = '0;

    // Refusal count hitting the limit buys exactly one forced cycle.
    state_d = ((state_q == ARB_NORMAL) && (starve_d == LIMIT)) ? ARB_FORCE : ARB_NORMAL;

    tag_d.dbg = dbg_own;
    tag_d.rd  = dmem_read_enable_o;

    dbg_rvalid_o    = tag_q.dbg & tag_q.rd & ~reset_i;
    dbg_read_data_o = dmem_read_data_i;
    cpu_read_data_o = dmem_read_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ARB_NORMAL;
      starve_q <= '0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      tag_q    <= tag_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized + directed bench for dmem_arbiter against a cycle-level
// ownership/starvation reference model and a shadow memory.
module tb_dmem_arbiter;

  localparam int LIM = 8;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] c_addr, c_wd, d_addr, d_wd;
  logic        c_re, d_req;
  logic [3:0]  c_wm, d_wm;
  logic        cpu_stall, dbg_gnt, dbg_rvalid, m_re;
  logic [31:0] cpu_rdata, dbg_rdata, m_addr, m_wd;
  logic [3:0]  m_wm;
  logic [31:0] m_rdata = '0;

  dmem_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk_i(clk), .reset_i(rst),
    .cpu_addr_i(c_addr), .cpu_read_enable_i(c_re), .cpu_write_data_i(c_wd),
    .cpu_write_mask_i(c_wm), .cpu_stall_o(cpu_stall), .cpu_read_data_o(cpu_rdata),
    .dbg_req_i(d_req), .dbg_addr_i(d_addr), .dbg_write_data_i(d_wd),
    .dbg_write_mask_i(d_wm), .dbg_gnt_o(dbg_gnt), .dbg_read_data_o(dbg_rdata),
    .dbg_rvalid_o(dbg_rvalid),
    .dmem_addr_o(m_addr), .dmem_read_enable_o(m_re), .dmem_write_data_o(m_wd),
    .dmem_write_mask_o(m_wm), .dmem_read_data_i(m_rdata)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] wm);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (wm[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Physical memory driven by the DUT port; mmem is the model's own copy.
  logic [31:0] pmem [0:255];
  logic [31:0] mmem [0:255];

  always @(posedge clk) begin
    if (m_re) m_rdata <= pmem[m_addr[9:2]];
    if (|m_wm) pmem[m_addr[9:2]] <= merge(pmem[m_addr[9:2]], m_wd, m_wm);
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  int          waited = 0;
  bit          forced = 0, pend_vld = 0, pend_dbg = 0;
  logic [31:0] pend_data = '0;
  bit          last_gnt = 0, last_stall = 0, obs_gnt = 0, obs_rv = 0;
  logic [31:0] obs_crd, obs_drd;

  task automatic cyc();
    bit          act, win, e_re, e_stall;
    logic [3:0]  e_wm;
    logic [31:0] e_addr, e_wd;
    @(negedge clk);
    act     = c_re || (c_wm != 4'h0);
    win     = !rst && d_req && (forced || !act);
    e_stall = !rst && forced && d_req && act;
    if (win) begin
      e_addr = d_addr; e_wd = d_wd; e_re = (d_wm == 4'h0); e_wm = d_wm;
    end else begin
      e_addr = c_addr; e_wd = c_wd; e_re = c_re && !rst; e_wm = rst ? 4'h0 : c_wm;
    end
    chk("gnt", dbg_gnt, win);
    chk("stall", cpu_stall, e_stall);
    chk("rvalid", dbg_rvalid, !rst && pend_dbg);
    chk("port_addr", m_addr, e_addr);
    chk("port_wdata", m_wd, e_wd);
    chk("port_re", m_re, e_re);
    chk("port_wm", m_wm, e_wm);
    if (!rst && pend_vld) begin
      chk("cpu_rdata", cpu_rdata, pend_data);
      if (pend_dbg) chk("dbg_rdata", dbg_rdata, pend_data);
    end
    obs_gnt = dbg_gnt; obs_rv = dbg_rvalid; obs_crd = cpu_rdata; obs_drd = dbg_rdata;
    last_gnt = win; last_stall = e_stall;
    pend_vld  = e_re;
    pend_dbg  = win && e_re;
    pend_data = mmem[e_addr[9:2]];
    mmem[e_addr[9:2]] = merge(mmem[e_addr[9:2]], e_wd, e_wm);
    if (rst || !d_req || win) waited = 0;
    else if (waited < LIM) waited++;
    forced = (waited == LIM);
    @(posedge clk); #1;
  endtask

  task automatic quiet();
    c_re = 0; c_wm = 0; d_req = 0; d_wm = 0;
  endtask

  task automatic rand_inputs();
    rst = ($urandom_range(63) == 0);
    if (!last_stall) begin
      c_addr = {22'd0, 8'($urandom), 2'b00};
      c_wd   = $urandom;
      case ($urandom_range(3))
        0:       begin c_re = 0; c_wm = 4'h0; end
        1, 2:    begin c_re = 1; c_wm = 4'h0; end
        default: begin c_re = 0; c_wm = 4'($urandom_range(15, 1)); end
      endcase
    end
    if (!(d_req && !last_gnt && $urandom_range(7) != 0)) begin
      d_req  = ($urandom_range(2) == 0);
      d_addr = {22'd0, 8'($urandom), 2'b00};
      d_wd   = $urandom;
      d_wm   = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom);
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) begin
      pmem[i] = $urandom;
      mmem[i] = pmem[i];
    end
    c_addr = 32'h100; c_wd = 32'h0; d_addr = 32'h0; d_wd = 32'h0;
    // Reset with both sides requesting: no strobes, no grant.
    rst = 1; c_re = 1; c_wm = 4'hF; d_req = 1; d_wm = 4'h0;
    cyc(); cyc();
    rst = 0; quiet(); cyc();

    // CPU load of 0x100.
    c_addr = 32'h100; c_re = 1; cyc();
    c_re = 0; cyc();
    chk("ld100_data", obs_crd, mmem[64]);
    chk("ld100_rv", obs_rv, 0);

    // Debug store then read-back of 0x200.
    d_req = 1; d_addr = 32'h200; d_wm = 4'hF; d_wd = 32'hDEADBEEF; cyc();
    chk("dbg_wr_gnt", obs_gnt, 1);
    d_req = 0; cyc();
    chk("dbg_wr_norv", obs_rv, 0);
    d_req = 1; d_wm = 4'h0; cyc();
    d_req = 0; cyc();
    chk("dbg_rd200", obs_drd, 32'hDEADBEEF);

    // Starvation: CPU loads every cycle, debug read of 0x40 held.
    quiet(); cyc();
    c_re = 1; d_req = 1; d_addr = 32'h40; d_wm = 4'h0; n = 0;
    for (int i = 1; i <= 20; i++) begin
      c_addr = {22'd0, 8'(i), 2'b00};
      cyc();
      if (obs_gnt) begin n = i; break; end
    end
    chk("starve_len", n, 9);
    d_req = 0; cyc();
    chk("force_rv", obs_rv, 1);

    // Forced grant over a CPU half-word store; store lands afterwards.
    quiet(); cyc();
    c_addr = 32'h80; c_wd = 32'h12345678; c_wm = 4'b0011;
    d_req = 1; d_addr = 32'h84; d_wm = 4'hF; d_wd = 32'hA5A5A5A5;
    for (int i = 0; i < 20 && !last_gnt; i++) cyc();
    d_req = 0; cyc();
    c_wm = 4'h0; c_re = 1; cyc();
    c_re = 0; cyc();
    chk("store_lo", obs_crd & 32'h0000FFFF, 32'h00005678);

    // Reset landing on the forced cycle abandons the grant.
    quiet(); cyc();
    c_re = 1; d_req = 1; d_addr = 32'h40; d_wm = 4'h0;
    repeat (LIM) cyc();
    rst = 1; cyc();
    rst = 0; cyc();
    chk("rst_force_rv", obs_rv, 0);
    chk("rst_force_gnt", obs_gnt, 0);

    // Debug drops exactly on the forced cycle.
    quiet(); cyc();
    c_re = 1; d_req = 1;
    repeat (LIM) cyc();
    d_req = 0; cyc();
    chk("drop_gnt", obs_gnt, 0);
    d_req = 1; cyc();
    chk("drop_restart", obs_gnt, 0);

    quiet(); last_stall = 0; last_gnt = 0;
    repeat (3000) begin
      rand_inputs();
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 8: consecutive cycles dbg may wait before it is granted ahead of the CPU.
REQ-002 clk_i  in  1  clock; single clock domain.
REQ-003 reset_i  in  1  reset; synchronous, active-high.
REQ-004 cpu_addr_i  in  32  CPU word address; bits [1:0] are zero.
REQ-005 cpu_read_enable_i  in  1  CPU load request.
REQ-006 cpu_write_data_i  in  32  CPU lane-shifted store data.
REQ-007 cpu_write_mask_i  in  4  CPU byte write enables.
REQ-008 cpu_stall_o  out  1  CPU must hold its request this cycle.
REQ-009 cpu_read_data_o  out  32  CPU load data.
REQ-010 dbg_req_i  in  1  secondary (debug/DMA) request.
REQ-011 dbg_addr_i  in  32  secondary word address.
REQ-012 dbg_write_data_i  in  32  secondary store data.
REQ-013 dbg_write_mask_i  in  4  secondary byte enables; 4'b0000 means read.
REQ-014 dbg_gnt_o  out  1  secondary request accepted this cycle.
REQ-015 dbg_read_data_o  out  32  secondary read data.
REQ-016 dbg_rvalid_o  out  1  dbg_read_data_o valid.
REQ-017 dmem_addr_o, dmem_read_enable_o, dmem_write_data_o, dmem_write_mask_o  out  32/1/32/4  shared memory port.
REQ-018 dmem_read_data_i  in  32  memory read data, one cycle after the read is issued.

Function
REQ-019 cpu_active SHALL equal cpu_read_enable_i OR (cpu_write_mask_i != 0).
REQ-020 State SHALL be ARB_NORMAL or ARB_FORCE; the starvation counter starve_r SHALL be clog2(STARVE_LIMIT+1) bits wide.
REQ-021 ARB_NORMAL, cpu_active=1: CPU owns the port, dbg_gnt_o=0, cpu_stall_o=0.
REQ-022 ARB_NORMAL, cpu_active=0, dbg_req_i=1: dbg owns the port, dbg_gnt_o=1.
REQ-023 Neither requester active: dmem_read_enable_o=0, dmem_write_mask_o=0, and dmem_addr_o/dmem_write_data_o take the CPU values.
REQ-024 starve_r SHALL increment when dbg_req_i=1 and dbg_gnt_o=0, saturating at STARVE_LIMIT, and SHALL clear on any dbg grant or when dbg_req_i=0.
REQ-025 ARB_NORMAL -> ARB_FORCE when starve_r reaches STARVE_LIMIT and dbg_req_i=1.
REQ-026 ARB_FORCE with dbg_req_i=1: dbg owns the port, dbg_gnt_o=1, and cpu_stall_o=cpu_active.
REQ-027 ARB_FORCE SHALL return to ARB_NORMAL after exactly one cycle; if dbg_req_i dropped, it grants nothing and cpu_stall_o=0.
REQ-028 The owner's address, data, read enable and mask SHALL drive the dmem outputs combinationally, with zero added latency.
REQ-029 A registered response tag (owner and read flag) SHALL route dmem_read_data_i the following cycle.
REQ-030 dbg_rvalid_o=1 exactly one cycle after a granted dbg read; never for dbg writes.
REQ-031 cpu_read_data_o SHALL be driven from dmem_read_data_i continuously, regardless of owner.
REQ-032 When dbg wins with cpu_active=1, the CPU's dmem_read_enable_o and mask SHALL NOT reach the port.

Reset
REQ-033 While reset_i=1: state=ARB_NORMAL, starve_r=0, response tag cleared, dbg_rvalid_o=0, dbg_gnt_o=0, cpu_stall_o=0.
REQ-034 While reset_i=1, dmem_read_enable_o=0 and dmem_write_mask_o=0.
REQ-035 Reset mid-ARB_FORCE SHALL abandon the forced grant; a pending dbg_rvalid_o SHALL NOT be emitted.

Structure
REQ-036 arb_state_t (ARB_NORMAL, ARB_FORCE) and DMEM_ARB_STARVE_LIMIT SHALL live in package cpu_common.
REQ-037 The block SHALL be a single module with no sub-modules.

Verification
REQ-038 CPU load 0x100 alone -> dmem_addr_o=0x100, read enable=1; next cycle cpu_read_data_o=mem[0x100], dbg_rvalid_o=0.
REQ-039 CPU idle, dbg write 0x200 mask 4'b1111 data 0xDEADBEEF -> same-cycle dbg_gnt_o=1; no dbg_rvalid_o; later read of 0x200 returns 0xDEADBEEF.
REQ-040 CPU active every cycle, dbg read 0x40 held, STARVE_LIMIT=8 -> dbg_gnt_o=0 for 8 cycles; 9th cycle dbg_gnt_o=1, cpu_stall_o=1; next cycle dbg_rvalid_o=1, cpu_stall_o=0.
REQ-041 Forced grant with CPU store mask 4'b0011 present -> dmem_write_mask_o=dbg mask; CPU store completes the following cycle, unchanged.
REQ-042 reset_i asserted during ARB_FORCE with dbg read -> next cycle state=ARB_NORMAL, dbg_rvalid_o=0, starve_r=0.
REQ-043 dbg_req_i drops at starve_r=STARVE_LIMIT -> no grant, no stall, starve_r=0.
